// File: rtl/u_dmem.sv
// u_dmem -- data-memory responder at the SRAM end of the LSU load/store port.
//
// Purpose:
//   DEPTH x 32-bit word array with per-byte write and read lane enables.
//   Read data appears one cycle after the request. After reset an init state
//   machine zero-fills the whole array, and dat_rdy stays low until it is done.
//   An access whose word index is >= DEPTH is dropped and flagged on dat_err.
//
// Handshake:
//   A request is the cycle in which any dat_we or dat_re bit is set. It is
//   accepted only while dat_rdy is high; there is no back-pressure once ready.
//   dat_rd, dat_err and dat_perr report on the cycle after the request.
//   dat_rd holds until the next read request completes.
//
// Ports:
//   clk      clock
//   rstn     asynchronous active-low reset
//   dat_a    byte address (word index = dat_a[AW-1:2]; dat_a[1:0] ignored)
//   dat_we   per-byte write enable
//   dat_wd   write data
//   dat_re   per-byte read enable
//   dat_rd   read data; lanes not enabled for the read return 8'h00
//   dat_rdy  high once init completes
//   dat_err  1-cycle out-of-range pulse, aligned with dat_rd
//   dat_perr 1-cycle parity error pulse (tied 0 unless DMEM_PARITY_EN)
//
// Build option:
//   DMEM_PARITY_EN  adds one even-parity bit per stored byte and drives
//                   dat_perr. tst_par_inv is a test hook: forcing one of its
//                   bits inverts the parity stored for that lane on a write.
//
// Debug: the FSM state is the internal signal state_q (ST_INIT / ST_RUN).

module u_dmem #(
  parameter int DEPTH = 16384,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] dat_a,
  input  logic [3:0]    dat_we,
  input  logic [31:0]   dat_wd,
  input  logic [3:0]    dat_re,
  output logic [31:0]   dat_rd,
  output logic          dat_rdy,
  output logic          dat_err,
  output logic          dat_perr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  assign dat_rdy = (state_q == ST_RUN);

  // ---------------------------------------------------------- decode
  logic [AW-3:0] word_idx;
  logic [IW-1:0] ram_idx;
  logic          in_range;
  logic          run, wr_req, rd_req, wr_ok, rd_ok;
  logic          unused_addr_lsbs;

  assign word_idx = dat_a[AW-1:2];
  assign ram_idx  = word_idx[IW-1:0];
  // Zero-extended by one bit so DEPTH == 2^(AW-2) still fits the compare.
  assign in_range = ({1'b0, word_idx} < (AW-1)'(DEPTH));
  assign unused_addr_lsbs = ^dat_a[1:0];

  assign run    = (state_q == ST_RUN);
  assign wr_req = run & (|dat_we);
  assign rd_req = run & (|dat_re);
  assign wr_ok  = wr_req & in_range;
  assign rd_ok  = rd_req & in_range;

  // ---------------------------------------------------------- storage
  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (dat_we[i]) mem[ram_idx][8*i +: 8] <= dat_wd[8*i +: 8];
      end
    end
  end

  // Synchronous read returns the pre-write word; the bypass below supplies
  // lanes written in the same cycle.
  always_ff @(posedge clk) begin
    if (rd_ok) ram_q <= mem[ram_idx];
  end

  // ------------------------------------------------ read-side control
  logic [3:0]  lane_q;   // lanes that return data (0 after an out-of-range read)
  logic [3:0]  byp_q;    // lanes written in the same cycle as the read
  logic [31:0] byp_d_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q  <= '0;
      byp_q   <= '0;
      byp_d_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // A combined read+write out of range still produces a single pulse.
      err_q <= (wr_req | rd_req) & ~in_range;
      if (rd_req) begin
        lane_q  <= in_range ? dat_re : 4'h0;
        byp_q   <= wr_ok ? dat_we : 4'h0;
        byp_d_q <= dat_wd;
      end
    end
  end

  always_comb begin
    dat_rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_q[i]) dat_rd[8*i +: 8] = byp_q[i] ? byp_d_q[8*i +: 8] : ram_q[8*i +: 8];
    end
  end

  assign dat_err = err_q;

`ifdef DMEM_PARITY_EN
  // ------------------------------------------------------------ parity
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_q;
  logic [3:0] tst_par_inv;
  logic       rd_v_q;
  logic [3:0] par_bad;

  assign tst_par_inv = 4'h0;

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (dat_we[i]) par_mem[ram_idx][i] <= (^dat_wd[8*i +: 8]) ^ tst_par_inv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) par_q <= par_mem[ram_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_v_q <= 1'b0;
    else       rd_v_q <= rd_ok;
  end

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < 4; i++) begin
      par_bad[i] = (^ram_q[8*i +: 8]) ^ par_q[i];
    end
  end

  // Bypassed lanes carry fresh write data and are never checked.
  assign dat_perr = rd_v_q & (|(lane_q & ~byp_q & par_bad));
`else
  assign dat_perr = 1'b0;
`endif

endmodule

// File: doc/u_dmem.md
Name: u_dmem

Overview:
Data-memory responder at the SRAM end of the load/store data port; it services the dat_* requests the LSU drives.
- Byte-lane write enables, byte-lane read enables.
- Read data returns with a fixed 1-cycle latency, aligned with the LSU's registered valid.
- After reset, an init state machine zero-fills the array before accepting accesses.
- Out-of-range accesses are flagged with an error pulse.

Parameters:
DEPTH, 16384, number of 32-bit words; must be a power of 2 and ≤ 2^(AW-2).
AW, 16, byte-address width of dat_a.

Ports:
clk  input  1  clock.
rstn  input  1  reset, asynchronous, active-low.
dat_a  input  AW  byte address; word index = dat_a[AW-1:2]; dat_a[1:0] ignored.
dat_we  input  4  per-byte write enable; bit i writes dat_wd[8i+7:8i].
dat_wd  input  32  write data.
dat_re  input  4  per-byte read enable.
dat_rd  output  32  read data, 1 cycle after request.
dat_rdy  output  1  high once init completes; requests accepted only while high.
dat_err  output  1  1-cycle pulse, same cycle as dat_rd, for an out-of-range access.
dat_perr  output  1  parity error pulse (see Optional Feature); tied 0 when feature is absent.

Behaviour:
- Reset values, asynchronous on rstn low: dat_rd=0, dat_rdy=0, dat_err=0, dat_perr=0, FSM=INIT, init counter=0. Reset does not clear the array itself.
- INIT state:
  - Each cycle, writes 0 to word[cnt] (all lanes) and increments cnt.
  - When cnt==DEPTH-1 has been written, moves to RUN next cycle; dat_rdy rises in that same cycle.
  - INIT lasts exactly DEPTH cycles after rstn deasserts.
  - dat_we/dat_re are ignored during INIT: no write, dat_rd=0, no dat_err.
- RUN state: stays in RUN until reset. Reset asserted mid-INIT or mid-RUN returns to INIT with cnt=0.
- Range check: access is in range iff dat_a[AW-1:2] < DEPTH.
- Write (any dat_we bit set, in range): updates only the enabled byte lanes at posedge; other lanes unchanged.
- Read (any dat_re bit set, in range):
  - At the next posedge, dat_rd lane i = stored byte if dat_re[i], else 8'h00.
  - dat_rd holds its value until the next read request completes.
  - Cycles with dat_re=0 leave dat_rd unchanged.
- Simultaneous read and write to the same word in one cycle is write-first:
  - Lanes written this cycle return dat_wd bytes.
  - Other read lanes return stored data.
- Out-of-range access:
  - Write: dropped, array unchanged.
  - Read: dat_rd=0 next cycle.
  - In both cases dat_err=1 for one cycle at the next posedge; it is asserted once even if read and write happen together.
- Back-to-back reads on consecutive cycles are fully pipelined, one result per cycle, no bubbles.
- Array storage: DEPTH x 32-bit, inferable as synchronous-write/synchronous-read RAM with a write-first bypass mux.

Optional Feature:
Macro: DMEM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, written with the byte. INIT writes parity 0.
  - On a read, each enabled lane's parity is recomputed; any mismatch pulses dat_perr=1 together with dat_rd. Data is still returned unmodified.
  - The write-first bypass path never flags an error.
  - A test hook is provided: a hierarchical force on the stored parity bit.
- Undefined: no parity storage; dat_perr is constant 0.

Test Plan:
1. Init (DEPTH=256): release rstn -> dat_rdy=0 for exactly 256 cycles, then 1. A read of 0x0040 with re=4'hF then returns 32'h0 one cycle later.
2. Byte write/read: write 0x0010 we=4'hF wd=32'hDEADBEEF, then we=4'b0010 wd=32'h00005500. Read re=4'hF -> 32'hDEAD55EF; read re=4'b1001 -> 32'hDE0000EF.
3. Write-first: already holding 0x0010=32'h11223344, issue we=4'b0001 wd=32'h000000AA and re=4'hF in the same cycle -> next-cycle dat_rd=32'h112233AA.
4. Out-of-range (DEPTH=256): write 0x0400 wd=32'h12345678 -> dat_err pulse, no array change. Read 0x0400 -> dat_rd=0, dat_err=1 for one cycle.
5. Reset mid-init: assert rstn low at cycle 100 of INIT, release -> dat_rdy stays low a further full 256 cycles. Requests issued while dat_rdy=0 produce no write and dat_rd=0.
6. With DMEM_PARITY_EN: write 0x0020 = 32'hA5A5A5A5, corrupt lane-2 parity, read re=4'hF -> dat_rd=32'hA5A5A5A5 and dat_perr=1. Read re=4'b0011 -> dat_perr=0.
